// File: rtl/keypad_pkg.sv
// Shared types, width helper and key layout for the multi-tap keypad controller.
// The key table covers the 4x4 layout; any index outside it decodes as KEY_NONE.
package keypad_pkg;

    localparam int KEY_IDX_W = 8;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_LETTER,
        KEY_SUBMIT_CHAR,
        KEY_CLEAR,
        KEY_SUBMIT_WORD
    } key_class_t;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } scan_state_t;

    typedef struct packed {
        key_class_t cls;
        logic [7:0] base;
        logic [2:0] len;
    } key_info_t;

    function automatic int cw(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic key_info_t key_decode(input logic [KEY_IDX_W-1:0] idx);
        key_info_t info;
        info = '{KEY_NONE, 8'h00, 3'd1};
        case (idx)
            8'd0:    info = '{KEY_LETTER, 8'h41, 3'd3};  // ABC
            8'd1:    info = '{KEY_LETTER, 8'h44, 3'd3};  // DEF
            8'd2:    info = '{KEY_LETTER, 8'h47, 3'd3};  // GHI
            8'd3:    info = '{KEY_LETTER, 8'h4A, 3'd3};  // JKL
            8'd4:    info = '{KEY_LETTER, 8'h4D, 3'd3};  // MNO
            8'd5:    info = '{KEY_LETTER, 8'h50, 3'd4};  // PQRS
            8'd6:    info = '{KEY_LETTER, 8'h54, 3'd3};  // TUV
            8'd7:    info = '{KEY_LETTER, 8'h57, 3'd4};  // WXYZ
            8'd12:   info = '{KEY_SUBMIT_CHAR, 8'h00, 3'd1};
            8'd13:   info = '{KEY_CLEAR, 8'h00, 3'd1};
            8'd14:   info = '{KEY_SUBMIT_WORD, 8'h00, 3'd1};
            default: info = '{KEY_NONE, 8'h00, 3'd1};
        endcase
        return info;
    endfunction

    function automatic logic [2:0] next_tap(input logic [2:0] tap, input logic [2:0] len);
        logic [2:0] inc;
        inc = tap + 3'd1;
        return (inc >= len) ? 3'd0 : inc;
    endfunction

endpackage

// File: rtl/keypad_scan_debounce.sv
// Column scan and press/release debounce for a ROWS x COLS matrix keypad.
//   state       | meaning
//   ST_SCAN     | rotate column drive, look for a single active row
//   ST_DEBOUNCE | column frozen, row must stay equal to the latch
//   ST_HELD     | key accepted, waiting for all rows to drop
//   ST_RELEASE  | rows must stay low before scanning resumes
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 500
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic [ROWS-1:0]      row_in,
    output logic [COLS-1:0]      col_out,
    output logic                 key_evt,
    output logic [KEY_IDX_W-1:0] key_idx
);

    localparam int COL_W  = cw(COLS);
    localparam int ROW_W  = cw(ROWS);
    localparam int SCAN_W = cw(SCAN_DIV);
    localparam int DEB_W  = cw(DEBOUNCE);
    localparam logic [SCAN_W-1:0] SCAN_LOAD = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEBOUNCE - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

    scan_state_t       state, state_next;
    logic [COL_W-1:0]  col_idx, col_idx_next;
    logic [ROW_W-1:0]  row_idx, row_idx_next;
    logic [ROWS-1:0]   row_lat, row_lat_next;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_next;
    logic [DEB_W-1:0]  deb_cnt, deb_cnt_next;
    logic [ROW_W-1:0]  row_enc;
    logic              row_onehot;

    always_comb begin
        row_onehot = $onehot(row_in);
        row_enc    = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_in[i]) row_enc = ROW_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= ST_SCAN;
            col_idx  <= '0;
            col_out  <= COLS'(1);
            row_idx  <= '0;
            row_lat  <= '0;
            scan_cnt <= SCAN_LOAD;
            deb_cnt  <= '0;
        end else begin
            state    <= state_next;
            col_idx  <= col_idx_next;
            col_out  <= COLS'(1) << col_idx_next;
            row_idx  <= row_idx_next;
            row_lat  <= row_lat_next;
            scan_cnt <= scan_cnt_next;
            deb_cnt  <= deb_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        col_idx_next  = col_idx;
        row_idx_next  = row_idx;
        row_lat_next  = row_lat;
        scan_cnt_next = scan_cnt;
        deb_cnt_next  = deb_cnt;
        key_evt       = 1'b0;
        case (state)
            ST_SCAN: begin
                if (row_onehot) begin
                    row_lat_next = row_in;
                    row_idx_next = row_enc;
                    deb_cnt_next = DEB_LOAD;
                    state_next   = ST_DEBOUNCE;
                end else if (scan_cnt == '0) begin
                    scan_cnt_next = SCAN_LOAD;
                    col_idx_next  = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
                end else begin
                    scan_cnt_next = scan_cnt - 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_in != row_lat) begin
                    state_next = ST_SCAN;
                end else if (deb_cnt == '0) begin
                    key_evt    = 1'b1;
                    state_next = ST_HELD;
                end else begin
                    deb_cnt_next = deb_cnt - 1'b1;
                end
            end
            ST_HELD: begin
                if (row_in == '0) begin
                    deb_cnt_next = DEB_LOAD;
                    state_next   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (row_in != '0) begin
                    state_next = ST_HELD;
                end else if (deb_cnt == '0) begin
                    scan_cnt_next = SCAN_LOAD;
                    state_next    = ST_SCAN;
                end else begin
                    deb_cnt_next = deb_cnt - 1'b1;
                end
            end
            default: state_next = ST_SCAN;
        endcase
    end

    assign key_idx = KEY_IDX_W'(row_idx) * KEY_IDX_W'(COLS) + KEY_IDX_W'(col_idx);

endmodule

// File: rtl/keypad_multitap.sv
// Multi-tap letter composition on top of the keypad scanner: tap timer,
// pending letter and the registered strobes consumed by the game FSMs.
module keypad_multitap
    import keypad_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEBOUNCE    = 500,
    parameter int TAP_TIMEOUT = 100000,
    parameter int AUTO_COMMIT = 0
) (
    input  logic            clk,
    input  logic            nRst,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [7:0]      cur_char,
    output logic            pending,
    output logic            char_strobe,
    output logic            word_strobe,
    output logic            clear_strobe,
    output logic            error
);

    localparam int TMR_W = cw(TAP_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TAP_TIMEOUT - 1);

    logic                 key_evt;
    logic [KEY_IDX_W-1:0] key_idx;
    key_info_t            info;

    logic [TMR_W-1:0]     tap_cnt, tap_cnt_next;
    logic                 timer_run, timer_run_next;
    logic [2:0]           tap, tap_next;
    logic [KEY_IDX_W-1:0] last_idx, last_idx_next;
    logic [7:0]           cur_char_next;
    logic                 pending_next;
    logic                 char_next, word_next, clear_next, error_next;
    logic                 expire, same_key;

    keypad_scan_debounce #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk     (clk),
        .nRst    (nRst),
        .row_in  (row_in),
        .col_out (col_out),
        .key_evt (key_evt),
        .key_idx (key_idx)
    );

    assign info = key_decode(key_idx);

    // An event landing on the expiry cycle counts as post-timeout.
    assign expire   = timer_run && (tap_cnt == '0);
    assign same_key = pending && timer_run && !expire && (key_idx == last_idx);

    always_ff @(posedge clk) begin
        if (!nRst) begin
            tap_cnt      <= '0;
            timer_run    <= 1'b0;
            tap          <= '0;
            last_idx     <= '0;
            cur_char     <= 8'h00;
            pending      <= 1'b0;
            char_strobe  <= 1'b0;
            word_strobe  <= 1'b0;
            clear_strobe <= 1'b0;
            error        <= 1'b0;
        end else begin
            tap_cnt      <= tap_cnt_next;
            timer_run    <= timer_run_next;
            tap          <= tap_next;
            last_idx     <= last_idx_next;
            cur_char     <= cur_char_next;
            pending      <= pending_next;
            char_strobe  <= char_next;
            word_strobe  <= word_next;
            clear_strobe <= clear_next;
            error        <= error_next;
        end
    end

    always_comb begin
        tap_cnt_next   = tap_cnt;
        timer_run_next = timer_run;
        tap_next       = tap;
        last_idx_next  = last_idx;
        cur_char_next  = cur_char;
        pending_next   = pending;
        char_next      = 1'b0;
        word_next      = 1'b0;
        clear_next     = 1'b0;
        error_next     = 1'b0;

        if (timer_run) begin
            if (tap_cnt == '0) timer_run_next = 1'b0;
            else               tap_cnt_next   = tap_cnt - 1'b1;
        end

        if (key_evt) begin
            case (info.cls)
                KEY_LETTER: begin
                    tap_next       = same_key ? next_tap(tap, info.len) : 3'd0;
                    cur_char_next  = info.base + {5'b0, tap_next};
                    pending_next   = 1'b1;
                    last_idx_next  = key_idx;
                    tap_cnt_next   = TMR_LOAD;
                    timer_run_next = 1'b1;
                end
                KEY_SUBMIT_CHAR: begin
                    if (pending) begin
                        char_next    = 1'b1;
                        pending_next = 1'b0;
                    end else begin
                        error_next = 1'b1;
                    end
                end
                KEY_CLEAR: begin
                    pending_next  = 1'b0;
                    cur_char_next = 8'h00;
                    clear_next    = 1'b1;
                end
                KEY_SUBMIT_WORD: begin
                    if (!pending) word_next  = 1'b1;
                    else          error_next = 1'b1;
                end
                default: ;
            endcase
        end else if (expire && (AUTO_COMMIT != 0) && pending) begin
            char_next    = 1'b1;
            pending_next = 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_multitap.sv
// Bench for keypad_multitap: directed scenarios plus random key sequences,
// checked against a string-table multi-tap model with press-time bookkeeping.
module tb_keypad_multitap;

    localparam int TAPTO = 200;

    logic       clk = 1'b0;
    logic       nRst;
    logic [3:0] row_a, col_a, row_c, col_c;
    logic [7:0] cur_a, cur_c;
    logic       pend_a, chs_a, ws_a, cs_a, err_a;
    logic       pend_c, chs_c, ws_c, cs_c, err_c;

    logic       down_a = 1'b0, frc_a = 1'b0;
    logic [1:0] kr_a = '0, kc_a = '0;
    logic [3:0] frc_val_a = '0;
    logic       down_c = 1'b0, frc_c = 1'b0;
    logic [1:0] kr_c = '0, kc_c = '0;
    logic [3:0] frc_val_c = '0;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int cnt_chs_a = 0, cnt_ws_a = 0, cnt_cs_a = 0, cnt_err_a = 0;
    int run_a = 0, max_run_a = 0, cnt_chs_c = 0, cnt_other_c = 0;
    logic [7:0] chs_char_a = '0, chs_char_c = '0;

    string      grp [16];
    bit         m_pend;
    logic [7:0] m_char;
    int         m_key, m_tap, m_t_letter;
    int         e_chs = 0, e_ws = 0, e_cs = 0, e_err = 0;

    always #5 clk = ~clk;

    keypad_multitap #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(8), .TAP_TIMEOUT(TAPTO), .AUTO_COMMIT(0)
    ) dut_a (
        .clk(clk), .nRst(nRst), .row_in(row_a), .col_out(col_a), .cur_char(cur_a),
        .pending(pend_a), .char_strobe(chs_a), .word_strobe(ws_a),
        .clear_strobe(cs_a), .error(err_a)
    );

    keypad_multitap #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(8), .TAP_TIMEOUT(TAPTO), .AUTO_COMMIT(1)
    ) dut_c (
        .clk(clk), .nRst(nRst), .row_in(row_c), .col_out(col_c), .cur_char(cur_c),
        .pending(pend_c), .char_strobe(chs_c), .word_strobe(ws_c),
        .clear_strobe(cs_c), .error(err_c)
    );

    // Matrix keypad: a closed switch connects its row to its column drive.
    always_comb begin
        row_a = frc_a ? frc_val_a : 4'b0000;
        if (!frc_a && down_a && col_a[kc_a]) row_a[kr_a] = 1'b1;
        row_c = frc_c ? frc_val_c : 4'b0000;
        if (!frc_c && down_c && col_c[kc_c]) row_c[kr_c] = 1'b1;
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (chs_a) begin
            cnt_chs_a++;
            chs_char_a = cur_a;
            run_a++;
            if (run_a > max_run_a) max_run_a = run_a;
        end else begin
            run_a = 0;
        end
        if (ws_a)  cnt_ws_a++;
        if (cs_a)  cnt_cs_a++;
        if (err_a) cnt_err_a++;
        if (chs_c) begin
            cnt_chs_c++;
            chs_char_c = cur_c;
        end
        if (ws_c || cs_c || err_c) cnt_other_c++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_event(input int idx, input int t);
        if (grp[idx].len() > 0) begin
            if (m_pend && idx == m_key && (t - m_t_letter) < TAPTO)
                m_tap = (m_tap + 1) % grp[idx].len();
            else
                m_tap = 0;
            m_key      = idx;
            m_pend     = 1'b1;
            m_char     = grp[idx][m_tap];
            m_t_letter = t;
        end else if (idx == 12) begin
            if (m_pend) begin e_chs++; m_pend = 1'b0; end
            else e_err++;
        end else if (idx == 13) begin
            m_pend = 1'b0;
            m_char = 8'h00;
            e_cs++;
        end else if (idx == 14) begin
            if (!m_pend) e_ws++;
            else e_err++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_char"},    32'(cur_a),     32'(m_char));
        chk({tag, "_pending"}, 32'(pend_a),    32'(m_pend));
        chk({tag, "_n_char"},  32'(cnt_chs_a), 32'(e_chs));
        chk({tag, "_n_word"},  32'(cnt_ws_a),  32'(e_ws));
        chk({tag, "_n_clear"}, 32'(cnt_cs_a),  32'(e_cs));
        chk({tag, "_n_error"}, 32'(cnt_err_a), 32'(e_err));
    endtask

    task automatic press_a(input int r, input int c, input int gap);
        int t;
        t = cyc;
        kr_a = 2'(r);
        kc_a = 2'(c);
        down_a = 1'b1;
        step(40);
        down_a = 1'b0;
        step(20 + gap);
        model_event(r * 4 + c, t);
        check_model($sformatf("key%0d%0d", r, c));
    endtask

    initial begin
        int snap, changes, key, col_pos;
        logic [3:0] prev_col, col_snap;
        bit seen;

        grp = '{"ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ",
                "", "", "", "", "", "", "", ""};
        m_pend = 1'b0; m_char = 8'h00; m_key = -1; m_tap = 0; m_t_letter = 0;

        nRst = 1'b0;
        step(3);
        nRst = 1'b1;
        chk("rst_col",     32'(col_a),  32'h1);
        chk("rst_char",    32'(cur_a),  32'h0);
        chk("rst_pending", 32'(pend_a), 32'h0);
        chk("rst_strobes", 32'({chs_a, ws_a, cs_a, err_a}), 32'h0);
        chk("rst_col_c",   32'(col_c),  32'h1);
        chk("rst_pend_c",  32'(pend_c), 32'h0);

        // reset while key (0,0) is being debounced
        kr_a = 2'd0; kc_a = 2'd0; down_a = 1'b1;
        step(4);
        nRst = 1'b0; down_a = 1'b0;
        step(1);
        nRst = 1'b1;
        chk("middeb_col",     32'(col_a),  32'h1);
        chk("middeb_pending", 32'(pend_a), 32'h0);
        chk("middeb_char",    32'(cur_a),  32'h0);
        snap = cnt_chs_a + cnt_ws_a + cnt_cs_a + cnt_err_a;
        step(20);
        chk("middeb_no_strobe", 32'(cnt_chs_a + cnt_ws_a + cnt_cs_a + cnt_err_a), 32'(snap));
        chk("middeb_pending2",  32'(pend_a), 32'h0);

        // P -> Q -> R, then commit
        press_a(1, 1, 0);
        press_a(1, 1, 0);
        press_a(1, 1, 0);
        press_a(3, 0, 0);
        chk("commit_char",  32'(chs_char_a), 32'h52);
        chk("commit_width", 32'(max_run_a),  32'd1);

        // W X Y Z W, then restart at base after idling past the timeout
        press_a(1, 3, 0);
        press_a(1, 3, 0);
        press_a(1, 3, 0);
        press_a(1, 3, 0);
        press_a(1, 3, 250);
        press_a(1, 3, 0);

        // short glitch and multi-hot rows must not produce a key
        frc_a = 1'b1; frc_val_a = 4'b0001;
        step(5);
        frc_val_a = 4'b0000;
        step(20);
        frc_val_a = 4'b0011;
        changes = 0;
        prev_col = col_a;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (col_a != prev_col) changes++;
            prev_col = col_a;
        end
        n_chk++;
        assert (changes >= 4) else begin
            n_fail++;
            $error("FAIL multihot_rotate: observed=%0d expected>=4", changes);
        end
        frc_a = 1'b0;
        step(20);
        check_model("glitch");

        // illegal requests, clear and word submit
        press_a(3, 1, 0);
        press_a(3, 0, 0);
        press_a(0, 0, 0);
        press_a(3, 2, 0);
        press_a(3, 1, 0);
        press_a(3, 2, 0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0 && m_key >= 0) key = m_key;
            else key = int'($urandom_range(0, 15));
            press_a(key / 4, key % 4,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(260, 300))
                                                : int'($urandom_range(0, 40)));
        end
        chk("rand_width", 32'(max_run_a), 32'd1);

        // auto-commit on timeout
        kr_c = 2'd0; kc_c = 2'd2; down_c = 1'b1;
        step(40);
        down_c = 1'b0;
        step(20);
        chk("ac_pending", 32'(pend_c), 32'h1);
        chk("ac_char",    32'(cur_c),  32'h47);
        step(200);
        chk("ac_n_char",   32'(cnt_chs_c),  32'd1);
        chk("ac_strobe_c", 32'(chs_char_c), 32'h47);
        chk("ac_pend_off", 32'(pend_c),     32'h0);

        // new key event landing on the expiry cycle
        kr_c = 2'd0; kc_c = 2'd1; down_c = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (pend_c) seen = 1'b1;
        end
        chk("tie_press_seen", 32'(seen), 32'h1);
        down_c = 1'b0;
        repeat (191) @(posedge clk);
        #1;
        frc_c = 1'b1; frc_val_c = 4'b0001;
        col_snap = col_c;
        col_pos = 0;
        for (int i = 0; i < 4; i++) if (col_snap[i]) col_pos = i;
        step(12);
        frc_c = 1'b0;
        step(30);
        chk("tie_no_commit", 32'(cnt_chs_c), 32'd1);
        chk("tie_pending",   32'(pend_c),    32'h1);
        chk("tie_char",      32'(cur_c),     32'(grp[col_pos][0]));
        chk("c_no_other",    32'(cnt_other_c), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/keypad_multitap.md
Name: keypad_multitap

Overview:
- Parametrised successor to the single-keypad letter-entry logic used on the host and player sides of the Wireless Hangman design.
- Scans a ROWS x COLS matrix keypad, debounces presses, and turns repeated presses of one key into a cycling letter (phone-style multi-tap).
- Emits registered strobes for letter submit, word submit and clear to the game/message FSMs.
- Adds configurable debounce, tap timeout, optional auto-commit and an error flag.

Parameters:
- ROWS, 4, keypad row count (row_in width).
- COLS, 4, keypad column count (col_out width).
- SCAN_DIV, 1000, clk cycles each column is driven while idle.
- DEBOUNCE, 500, consecutive identical samples required for press and for release.
- TAP_TIMEOUT, 100000, clk cycles after a letter press within which the same key advances the letter.
- AUTO_COMMIT, 0, 1 = timeout expiry commits the pending letter.

Ports:
- clk  in  1  system clock.
- nRst  in  1  synchronous active-low reset.
- row_in  in  ROWS  keypad row sense, active-high.
- col_out  out  COLS  one-hot column drive.
- cur_char  out  8  ASCII of pending/committed letter.
- pending  out  1  a letter is being composed.
- char_strobe  out  1  1-cycle pulse: cur_char committed.
- word_strobe  out  1  1-cycle pulse: word submit.
- clear_strobe  out  1  1-cycle pulse: pending letter discarded.
- error  out  1  1-cycle pulse: illegal request.

Behaviour:
- Reset (nRst=0 at posedge): col_out=1 (col 0), cur_char=8'h00, pending=0, all strobes and error=0, FSM=SCAN, counters cleared. Applies mid-debounce or mid-tap; no strobe is emitted.
- FSM states are SCAN, DEBOUNCE, HELD and RELEASE.
- SCAN: col_out rotates left every SCAN_DIV cycles (wraps col COLS-1 -> col 0). If row_in is one-hot, latch row, freeze col_out and go to DEBOUNCE. Zero or multi-hot row_in: stay in SCAN.
- DEBOUNCE: row_in must equal the latch for DEBOUNCE cycles. A mismatch returns to SCAN with no event. On success, raise a 1-cycle key event with key index = row*COLS+col, then go to HELD.
- HELD: wait for row_in==0, then go to RELEASE.
- RELEASE: row_in must stay 0 for DEBOUNCE cycles, then go to SCAN (column resumes rotating). Nonzero row_in returns to HELD.
- Key events are decoded by a table lookup giving a class and, for letters, a base char and group length.
- LETTER event, pending and same key and timer running: tap index = (tap+1) mod len, i.e. wraps to base. cur_char = base+tap; timer restarts.
- LETTER event otherwise (different key, timer expired, or nothing pending): tap=0, cur_char=base, pending=1, timer restarts. The previous pending letter is replaced without a strobe.
- SUBMIT_CHAR: if pending, char_strobe=1 and pending=0; cur_char holds its value. If not pending, error=1.
- CLEAR: pending=0, cur_char=8'h00, clear_strobe=1.
- SUBMIT_WORD: if not pending, word_strobe=1. If pending, error=1 and nothing else happens.
- NONE: ignored.
- Timer expiry with AUTO_COMMIT=1 and pending: char_strobe=1, pending=0. With AUTO_COMMIT=0: pending is held and the next press of the same key restarts at base.
- Key event and timer expiry in the same cycle: the key event wins and is treated as post-timeout. No auto-commit strobe is issued.
- Latency: strobes and cur_char update on the clock edge after the key-event cycle, i.e. (DEBOUNCE+1) cycles after stable press sampling begins. All outputs are registered.
- Counter widths use $clog2 of the parameter, minimum 1 bit.

Decomposition:
- keypad_pkg holds:
  - key_class_t enum {KEY_NONE, KEY_LETTER, KEY_SUBMIT_CHAR, KEY_CLEAR, KEY_SUBMIT_WORD}.
  - Key table function for the 4x4 layout:
    - row 0 cols 0-3: "ABC","DEF","GHI","JKL" (len 3).
    - row 1 cols 0-3: "MNO"(3), "PQRS"(4), "TUV"(3), "WXYZ"(4).
    - row 2: NONE.
    - row 3 col 0: SUBMIT_CHAR; col 1: CLEAR; col 2: SUBMIT_WORD; col 3: NONE.
  - Indices outside the table decode as NONE.
- Sub-module keypad_scan_debounce: SCAN/DEBOUNCE/HELD/RELEASE FSM. Outputs col_out, key_evt and key_idx. The top level holds the multi-tap, timer and strobe logic.

Test Plan:
- Bench parameters: SCAN_DIV=4, DEBOUNCE=8, TAP_TIMEOUT=200, AUTO_COMMIT=0.
- Reset mid-DEBOUNCE: col_out=4'b0001, pending=0, cur_char=8'h00; no strobe for 20 cycles.
- Press key (1,1) three times within timeout, then SUBMIT_CHAR: cur_char 'P'->'Q'->'R'. Then char_strobe=1 for exactly 1 cycle with cur_char=8'h52, pending=0.
- Press key (1,3) five times: W,X,Y,Z,W (wrap). Press (1,3) again after 250 idle cycles: cur_char='W', tap restarted.
- 5-cycle row glitch, then multi-hot row_in=4'b0011: no key event; col_out keeps rotating.
- SUBMIT_CHAR with nothing pending: error pulse, no char_strobe. SUBMIT_WORD while 'A' pending: error, no word_strobe. CLEAR then SUBMIT_WORD: clear_strobe, then word_strobe.
- AUTO_COMMIT=1: press (0,2) once, idle 200 cycles: char_strobe with cur_char='G'. Same-cycle expiry and new press: no auto-commit; cur_char becomes the new key's base.
